// File: rtl/change_dispense_controller.sv
// Change payout sequencer: pays a latched change amount one coin at a time,
// largest usable denomination first, driving one coin motor per pulse with a
// fixed on-time and a fixed gap. Reports completion, coins paid and shortfall.
module change_dispense_controller #(
    parameter int PRICE_WIDTH  = 16,
    parameter int PULSE_CYCLES = 50000,
    parameter int GAP_CYCLES   = 25000
) (
    input  logic                   clk_sys,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [PRICE_WIDTH-1:0] change_amount,
    input  logic                   abort,
    input  logic [8:0]             tube_empty,
    output logic [8:0]             change_motors,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [PRICE_WIDTH-1:0] shortfall,
    output logic [7:0]             coins_paid
);

    // One timer serves both the pulse and the gap phase, so size it for the longer one.
    localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_PULSE,
        ST_GAP,
        ST_FINISH
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [PRICE_WIDTH-1:0] remaining;
    logic [3:0]             sel;
    logic [TW-1:0]          timer;
    logic                   abort_latch;
    logic                   scan_found;
    logic [3:0]             scan_idx;
    logic                   pulse_last;
    logic                   gap_last;

    // Denomination table; index 8 (2000) is the default arm.
    function automatic logic [PRICE_WIDTH-1:0] coin_value(input logic [3:0] idx);
        case (idx)
            4'd0:    coin_value = PRICE_WIDTH'(1);
            4'd1:    coin_value = PRICE_WIDTH'(2);
            4'd2:    coin_value = PRICE_WIDTH'(5);
            4'd3:    coin_value = PRICE_WIDTH'(10);
            4'd4:    coin_value = PRICE_WIDTH'(20);
            4'd5:    coin_value = PRICE_WIDTH'(50);
            4'd6:    coin_value = PRICE_WIDTH'(100);
            4'd7:    coin_value = PRICE_WIDTH'(500);
            default: coin_value = PRICE_WIDTH'(2000);
        endcase
    endfunction

    assign pulse_last = (timer == TW'(PULSE_CYCLES - 1));
    assign gap_last   = (timer == TW'(GAP_CYCLES - 1));

    // Priority scan: the last match in ascending order is the largest coin that fits and is stocked.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (!tube_empty[i] && (coin_value(4'(i)) <= remaining)) begin
                scan_found = 1'b1;
                scan_idx   = 4'(i);
            end
        end
    end

    // State register; reset drops straight to IDLE, which also kills any running motor.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (abort || abort_latch) begin
                    next_state = ST_FINISH;
                end else if (remaining == '0) begin
                    next_state = ST_FINISH;
                end else if (scan_found) begin
                    next_state = ST_PULSE;
                end else begin
                    next_state = ST_FINISH;
                end
            end
            ST_PULSE: begin
                if (pulse_last) begin
                    next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_last) begin
                    next_state = ST_SELECT;
                end
            end
            ST_FINISH: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Phase timer: counts while staying in PULSE or GAP, restarts from zero on every phase change.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (((state == ST_PULSE) || (state == ST_GAP)) && (next_state == state)) begin
            timer <= timer + TW'(1);
        end else begin
            timer <= '0;
        end
    end

    // Payout datapath. Shortfall and error are loaded as FINISH is entered so they are valid alongside done.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            remaining   <= '0;
            sel         <= 4'd0;
            coins_paid  <= 8'd0;
            shortfall   <= '0;
            error       <= 1'b0;
            abort_latch <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining  <= change_amount;
                        coins_paid <= 8'd0;
                        shortfall  <= '0;
                        error      <= 1'b0;
                    end
                end
                ST_SELECT: begin
                    if (next_state == ST_PULSE) begin
                        sel <= scan_idx;
                    end
                    if (next_state == ST_FINISH) begin
                        shortfall <= remaining;
                        error     <= (remaining != '0);
                    end
                end
                ST_PULSE: begin
                    if (abort) begin
                        abort_latch <= 1'b1;
                    end
                    if (pulse_last) begin
                        remaining <= remaining - coin_value(sel);
                        if (coins_paid != 8'hFF) begin
                            coins_paid <= coins_paid + 8'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        abort_latch <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    abort_latch <= 1'b0;
                end
                default: begin
                    abort_latch <= 1'b0;
                end
            endcase
        end
    end

    assign change_motors = (state == ST_PULSE) ? (9'd1 << sel) : 9'd0;
    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_FINISH);

endmodule

// File: tb/tb_change_dispense_controller.sv
// Directed bench for change_dispense_controller with short pulse/gap timing.
module tb_change_dispense_controller;

    localparam int PW = 16;

    logic          clk_sys;
    logic          rst_n;
    logic          start;
    logic [PW-1:0] change_amount;
    logic          abort;
    logic [8:0]    tube_empty;
    logic [8:0]    change_motors;
    logic          busy;
    logic          done;
    logic          error;
    logic [PW-1:0] shortfall;
    logic [7:0]    coins_paid;

    int errors;
    int checks;

    // Trace captured by collect(); comparisons are made by the test tasks.
    logic [8:0]    pulse_seq [16];
    int            pulse_len [16];
    int            pulse_cnt;
    int            done_cycle;
    logic          busy_at0;
    logic          done_err;
    logic [PW-1:0] done_short;
    logic [7:0]    done_coins;

    change_dispense_controller #(
        .PRICE_WIDTH (PW),
        .PULSE_CYCLES(4),
        .GAP_CYCLES  (2)
    ) dut (
        .clk_sys      (clk_sys),
        .rst_n        (rst_n),
        .start        (start),
        .change_amount(change_amount),
        .abort        (abort),
        .tube_empty   (tube_empty),
        .change_motors(change_motors),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .shortfall    (shortfall),
        .coins_paid   (coins_paid)
    );

    // 10 ns clock.
    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Pulse start for one edge (E0); returns 1 time unit after E0.
    task automatic launch(input logic [PW-1:0] amount, input logic [8:0] empties);
        change_amount = amount;
        tube_empty    = empties;
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    // Record motor pulses and done until done or a cycle budget runs out; k counts edges since E0.
    task automatic collect(input int abort_at, input int start_at);
        logic [8:0] prev;
        prev       = 9'd0;
        pulse_cnt  = 0;
        done_cycle = -1;
        busy_at0   = busy;
        for (int k = 0; k < 200; k++) begin
            abort = (k == abort_at);
            start = (k == start_at);
            if (change_motors != 9'd0) begin
                if ((change_motors == prev) && (pulse_cnt > 0)) begin
                    if (pulse_cnt <= 16) pulse_len[pulse_cnt-1]++;
                end else begin
                    if (pulse_cnt < 16) begin
                        pulse_seq[pulse_cnt] = change_motors;
                        pulse_len[pulse_cnt] = 1;
                    end
                    pulse_cnt++;
                end
            end
            prev = change_motors;
            if (done) begin
                done_cycle = k;
                done_err   = error;
                done_short = shortfall;
                done_coins = coins_paid;
                break;
            end
            tick();
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (change_motors !== 9'd0) begin errors++; $display("[TB] FAIL reset_motors: got %b expected %b", change_motors, 9'd0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error: got %b expected 0", error); end
        checks++; if (shortfall !== 16'd0) begin errors++; $display("[TB] FAIL reset_shortfall: got %0d expected 0", shortfall); end
        checks++; if (coins_paid !== 8'd0) begin errors++; $display("[TB] FAIL reset_coins: got %0d expected 0", coins_paid); end
    endtask

    task automatic test_basic_25();
        logic [8:0] exp_seq [2];
        exp_seq = '{9'b000010000, 9'b000000100};
        launch(16'd25, 9'd0);
        collect(-1, -1);
        checks++; if (busy_at0 !== 1'b1) begin errors++; $display("[TB] FAIL b25_busy_e0: got %b expected 1", busy_at0); end
        checks++; if (pulse_cnt !== 2) begin errors++; $display("[TB] FAIL b25_pulses: got %0d expected 2", pulse_cnt); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (pulse_seq[i] !== exp_seq[i]) begin errors++; $display("[TB] FAIL b25_coin%0d: got %b expected %b", i, pulse_seq[i], exp_seq[i]); end
            checks++; if (pulse_len[i] !== 4) begin errors++; $display("[TB] FAIL b25_len%0d: got %0d expected 4", i, pulse_len[i]); end
        end
        checks++; if (done_cycle !== 15) begin errors++; $display("[TB] FAIL b25_done_cycle: got %0d expected 15", done_cycle); end
        checks++; if (done_coins !== 8'd2) begin errors++; $display("[TB] FAIL b25_coins: got %0d expected 2", done_coins); end
        checks++; if (done_short !== 16'd0) begin errors++; $display("[TB] FAIL b25_shortfall: got %0d expected 0", done_short); end
        checks++; if (done_err !== 1'b0) begin errors++; $display("[TB] FAIL b25_error: got %b expected 0", done_err); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b25_busy_after: got %b expected 0", busy); end
        checks++; if (coins_paid !== 8'd2) begin errors++; $display("[TB] FAIL b25_coins_held: got %0d expected 2", coins_paid); end
    endtask

    task automatic test_skip_empty_75();
        logic [8:0] exp_seq [5];
        exp_seq = '{9'b000010000, 9'b000010000, 9'b000010000, 9'b000001000, 9'b000000100};
        launch(16'd75, 9'b000100000);
        collect(-1, -1);
        checks++; if (pulse_cnt !== 5) begin errors++; $display("[TB] FAIL s75_pulses: got %0d expected 5", pulse_cnt); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (pulse_seq[i] !== exp_seq[i]) begin errors++; $display("[TB] FAIL s75_coin%0d: got %b expected %b", i, pulse_seq[i], exp_seq[i]); end
        end
        checks++; if (done_cycle !== 36) begin errors++; $display("[TB] FAIL s75_done_cycle: got %0d expected 36", done_cycle); end
        checks++; if (done_coins !== 8'd5) begin errors++; $display("[TB] FAIL s75_coins: got %0d expected 5", done_coins); end
        checks++; if (done_err !== 1'b0) begin errors++; $display("[TB] FAIL s75_error: got %b expected 0", done_err); end
        tick();
    endtask

    task automatic test_no_coin_3();
        launch(16'd3, 9'b000000011);
        collect(-1, -1);
        checks++; if (pulse_cnt !== 0) begin errors++; $display("[TB] FAIL n3_pulses: got %0d expected 0", pulse_cnt); end
        checks++; if (done_cycle !== 1) begin errors++; $display("[TB] FAIL n3_done_cycle: got %0d expected 1", done_cycle); end
        checks++; if (done_short !== 16'd3) begin errors++; $display("[TB] FAIL n3_shortfall: got %0d expected 3", done_short); end
        checks++; if (done_err !== 1'b1) begin errors++; $display("[TB] FAIL n3_error: got %b expected 1", done_err); end
        checks++; if (done_coins !== 8'd0) begin errors++; $display("[TB] FAIL n3_coins: got %0d expected 0", done_coins); end
        tick();
        checks++; if (shortfall !== 16'd3) begin errors++; $display("[TB] FAIL n3_shortfall_held: got %0d expected 3", shortfall); end
    endtask

    task automatic test_zero_amount();
        launch(16'd0, 9'd0);
        collect(-1, -1);
        checks++; if (pulse_cnt !== 0) begin errors++; $display("[TB] FAIL z0_pulses: got %0d expected 0", pulse_cnt); end
        checks++; if (done_cycle !== 1) begin errors++; $display("[TB] FAIL z0_done_cycle: got %0d expected 1", done_cycle); end
        checks++; if (done_err !== 1'b0) begin errors++; $display("[TB] FAIL z0_error: got %b expected 0", done_err); end
        tick();
    endtask

    task automatic test_large_4100();
        logic [8:0] exp_seq [3];
        exp_seq = '{9'b100000000, 9'b100000000, 9'b001000000};
        launch(16'd4100, 9'd0);
        change_amount = 16'd7;
        collect(-1, 3);
        checks++; if (pulse_cnt !== 3) begin errors++; $display("[TB] FAIL l4100_pulses: got %0d expected 3", pulse_cnt); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (pulse_seq[i] !== exp_seq[i]) begin errors++; $display("[TB] FAIL l4100_coin%0d: got %b expected %b", i, pulse_seq[i], exp_seq[i]); end
        end
        checks++; if (done_cycle !== 22) begin errors++; $display("[TB] FAIL l4100_done_cycle: got %0d expected 22", done_cycle); end
        checks++; if (done_coins !== 8'd3) begin errors++; $display("[TB] FAIL l4100_coins: got %0d expected 3", done_coins); end
        checks++; if (done_short !== 16'd0) begin errors++; $display("[TB] FAIL l4100_shortfall: got %0d expected 0", done_short); end
        tick();
    endtask

    task automatic test_abort_150();
        launch(16'd150, 9'd0);
        collect(2, -1);
        checks++; if (pulse_cnt !== 1) begin errors++; $display("[TB] FAIL a150_pulses: got %0d expected 1", pulse_cnt); end
        checks++; if (pulse_seq[0] !== 9'b001000000) begin errors++; $display("[TB] FAIL a150_coin: got %b expected %b", pulse_seq[0], 9'b001000000); end
        checks++; if (pulse_len[0] !== 4) begin errors++; $display("[TB] FAIL a150_len: got %0d expected 4", pulse_len[0]); end
        checks++; if (done_cycle !== 8) begin errors++; $display("[TB] FAIL a150_done_cycle: got %0d expected 8", done_cycle); end
        checks++; if (done_coins !== 8'd1) begin errors++; $display("[TB] FAIL a150_coins: got %0d expected 1", done_coins); end
        checks++; if (done_short !== 16'd50) begin errors++; $display("[TB] FAIL a150_shortfall: got %0d expected 50", done_short); end
        checks++; if (done_err !== 1'b1) begin errors++; $display("[TB] FAIL a150_error: got %b expected 1", done_err); end
        tick();
    endtask

    task automatic test_reset_mid_pulse();
        launch(16'd25, 9'd0);
        for (int k = 0; k < 9; k++) tick();
        checks++; if (change_motors !== 9'b000000100) begin errors++; $display("[TB] FAIL rm_motor_before: got %b expected %b", change_motors, 9'b000000100); end
        checks++; if (coins_paid !== 8'd1) begin errors++; $display("[TB] FAIL rm_coins_before: got %0d expected 1", coins_paid); end
        rst_n = 1'b0;
        #1;
        checks++; if (change_motors !== 9'd0) begin errors++; $display("[TB] FAIL rm_motor: got %b expected 0", change_motors); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rm_busy: got %b expected 0", busy); end
        checks++; if (coins_paid !== 8'd0) begin errors++; $display("[TB] FAIL rm_coins: got %0d expected 0", coins_paid); end
        #3;
        rst_n = 1'b1;
        tick();
        launch(16'd1, 9'd0);
        collect(-1, -1);
        checks++; if (pulse_cnt !== 1) begin errors++; $display("[TB] FAIL rm1_pulses: got %0d expected 1", pulse_cnt); end
        checks++; if (pulse_seq[0] !== 9'b000000001) begin errors++; $display("[TB] FAIL rm1_coin: got %b expected %b", pulse_seq[0], 9'b000000001); end
        checks++; if (pulse_len[0] !== 4) begin errors++; $display("[TB] FAIL rm1_len: got %0d expected 4", pulse_len[0]); end
        checks++; if (done_coins !== 8'd1) begin errors++; $display("[TB] FAIL rm1_coins: got %0d expected 1", done_coins); end
        tick();
    endtask

    // Test sequence.
    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        change_amount = '0;
        tube_empty    = 9'd0;
        #12;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_basic_25();
        test_skip_empty_75();
        test_no_coin_3();
        test_zero_amount();
        test_large_4100();
        test_abort_150();
        test_reset_mid_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/change_dispense_controller.md
# change_dispense_controller

Sequencer for the vending machine's nine change-coin motors. After a paid transaction it accepts a change amount and pays it out one coin at a time, largest denomination first, skipping empty tubes. Each motor pulse has a fixed on-time and is followed by a fixed gap. The block sits between the payment logic, which produces the overpayment, and the `change_motors` outputs. It reports completion, coins paid and any unpaid shortfall.

## Interface
- `PRICE_WIDTH`, 16, width of money amounts in units.
- `PULSE_CYCLES`, 50000, motor on-time in clk_sys cycles (≥1).
- `GAP_CYCLES`, 25000, idle time between consecutive coins in clk_sys cycles (≥1).
- `clk_sys` in 1: single clock; all state is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request, sampled only in IDLE; latches `change_amount`.
- `change_amount` in PRICE_WIDTH: change to pay, in units.
- `abort` in 1: stop payout early.
- `tube_empty` in 9: per-tube empty sensor, 1 = empty. Bit index equals denomination index.
- `change_motors` out 9: one-hot motor drive, bit i = denomination i.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: valid with `done`; high when `shortfall` ≠ 0.
- `shortfall` out PRICE_WIDTH: amount left unpaid; held until the next `start`.
- `coins_paid` out 8: coins ejected this transaction, saturating at 255; held until the next `start`.

## Operation
- Denomination index 0..8 maps to values 1, 2, 5, 10, 20, 50, 100, 500, 2000.
- **IDLE**
  - If `start`=1: `remaining` ← `change_amount`; `coins_paid`, `shortfall` and `error` ← 0; go to SELECT.
- **SELECT** (one cycle)
  - If `abort` is high, or the abort latch is set: go to FINISH.
  - Else if `remaining`=0: go to FINISH.
  - Else pick the highest i with value(i) ≤ `remaining` and `tube_empty[i]`=0, using a combinational priority scan. If one exists, `sel` ← i and go to PULSE. If none exists, go to FINISH.
- **PULSE**
  - `change_motors` = 1<<`sel` for exactly PULSE_CYCLES cycles.
  - On the last cycle: `remaining` ← `remaining` − value(`sel`); `coins_paid` increments (saturating); go to GAP.
- **GAP**
  - Motors are 0 for GAP_CYCLES cycles, then go to SELECT.
- **FINISH** (one cycle)
  - `done`=1; `shortfall` ← `remaining`; `error` ← (`remaining` ≠ 0); clear the abort latch; go to IDLE.
- **Abort**
  - An `abort` seen in PULSE or GAP sets an internal latch.
  - A pulse in progress is always completed and counted, so a coin is never half-ejected.
  - GAP continues; the next SELECT then goes to FINISH.
  - `abort` is ignored in IDLE and FINISH.
- **Other rules**
  - `start` outside IDLE is ignored.
  - `tube_empty` is sampled only in SELECT. A tube emptying mid-pulse does not shorten the pulse.
  - Subtraction never underflows, because value(`sel`) ≤ `remaining` by construction. Internal value constants are PRICE_WIDTH wide.

## Timing
- All outputs are decoded from registered state or are registers; outputs carry no glitches.
  - `change_motors` is nonzero only in PULSE.
  - `done` is high only in FINISH.
- **Reset** (`rst_n` low) immediately gives:
  - state IDLE;
  - `change_motors`=0, `busy`=0, `done`=0, `error`=0;
  - `shortfall`=0, `coins_paid`=0, `remaining`=0, abort latch cleared.
  - Reset in the middle of a pulse drops the motor asynchronously. No coin is counted for that pulse.
- `start` is sampled at edge E0.
  - `busy` is high from E0.
  - The first motor turns on at E1 (SELECT lasts one cycle).
- Per coin: PULSE_CYCLES + GAP_CYCLES + 1 cycles. The +1 is the SELECT cycle.
- Amount 0, or no usable coin: `done` is high in the cycle after E1 (2 cycles after start). No motor activity.
- After the last coin: GAP, then SELECT, then FINISH. `done` is high GAP_CYCLES+1 cycles after that motor turns off.
- `done` and `busy` are both high during FINISH. `busy` falls at the next edge.
- A new `start` is accepted on the first edge at which the block is in IDLE.

## Test plan
Bench parameters: PULSE_CYCLES=4, GAP_CYCLES=2, all tubes full unless stated.
- `change_amount`=25 → motors `9'b000010000` for 4 cycles, then `9'b000000100` for 4 cycles; `done` with `coins_paid`=2, `shortfall`=0, `error`=0.
- `change_amount`=75 with `tube_empty[5]`=1 → coins 20, 20, 20, 10, 5; `coins_paid`=5; `error`=0.
- `change_amount`=3 with `tube_empty[1:0]`=2'b11 → no motor pulses; `done` 2 cycles after start; `shortfall`=3, `error`=1.
- `change_amount`=4100 → coins 2000, 2000, 100; `coins_paid`=3. Also check `start` pulsed during the payout is ignored.
- `change_amount`=150 with `abort` asserted in the 2nd cycle of the first pulse → the 100 pulse completes at its full 4 cycles; `done` with `coins_paid`=1, `shortfall`=50, `error`=1.
- `rst_n` dropped in the middle of a pulse → `change_motors`=0 and all outputs return to reset values immediately. A following `start` with amount 1 → single `9'b000000001` pulse, `coins_paid`=1.
